// File: rtl/uart_pkg.sv
// Shared UART encodings, per-frame config struct and baud divisor helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] baud_sel;
        logic [1:0] data_bits;
        logic [1:0] parity;
        logic       stop2;
    } cfg_t;

    localparam int unsigned BAUD_RATE [8] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    // Clock cycles per serial bit; only ever evaluated on constants.
    function automatic int unsigned bit_nclk(input int unsigned clk_mhz,
                                             input logic [2:0]  sel);
        return (clk_mhz * 1000000) / BAUD_RATE[sel];
    endfunction

    function automatic logic frame_parity(input logic [7:0] data,
                                          input logic [1:0] data_bits,
                                          input logic       odd);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - data_bits);
        return (^(data & mask)) ^ odd;
    endfunction

    function automatic logic has_parity(input logic [1:0] parity);
        return (parity == PAR_EVEN) || (parity == PAR_ODD);
    endfunction

    // Index of the last data bit: 5..8 data bits -> 4..7.
    function automatic logic [3:0] last_data_idx(input logic [1:0] data_bits);
        return {2'b01, data_bits};
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: one-cycle bit_tick_o at the last cycle of every bit period.
// Latency: first tick BIT_NCLK cycles after enable rises; counter held at 0 when disabled.
// Backpressure: none, free-running while enabled; restart_i forces the count back to 0.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_MHZ = 50,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_sel_i,
    input  logic       enable_i,
    input  logic       restart_i,
    output logic       bit_tick_o
);

    localparam logic [DIV_W-1:0] DIV_M1 [8] = '{
        DIV_W'(bit_nclk(CLK_MHZ, 3'd0) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd1) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd2) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd3) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd4) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd5) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd6) - 1),
        DIV_W'(bit_nclk(CLK_MHZ, 3'd7) - 1)
    };

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == DIV_M1[baud_sel_i]);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (!enable_i || restart_i || at_end) begin
            cnt_d = '0;
        end
    end

    assign bit_tick_o = enable_i & ~restart_i & at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd parity, 1/2 stop).
// Latency: line falls one clk after the transfer edge; done pulses in the IDLE cycle after stop.
// Backpressure: tx_ready_o high only in IDLE; a held tx_valid_i transfers in that same cycle.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned UART_CLK_MHZ = 50,
    parameter int unsigned DIV_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_sel_i,
    input  logic [1:0] data_bits_i,
    input  logic [1:0] parity_i,
    input  logic       stop2_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       rs232_tx_o
);

    state_e     state_q, state_d;
    cfg_t       cfg_q, cfg_d;
    logic [7:0] sh_q, sh_d;
    logic       par_q, par_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       line_q, line_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       xfer;
    logic       bit_tick;

    assign tx_ready_o = (state_q == ST_IDLE);
    assign xfer       = tx_valid_i & tx_ready_o;

    uart_baud_timer #(
        .CLK_MHZ (UART_CLK_MHZ),
        .DIV_W   (DIV_W)
    ) u_baud_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_sel_i (cfg_q.baud_sel),
        .enable_i   (state_q != ST_IDLE),
        .restart_i  (xfer),
        .bit_tick_o (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Config and data are captured only at the transfer edge, so mid-frame
    // input changes cannot disturb the frame on the line.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        sh_d      = sh_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_START;
                    cfg_d     = '{baud_sel:  baud_sel_i,
                                  data_bits: data_bits_i,
                                  parity:    parity_i,
                                  stop2:     stop2_i};
                    sh_d      = tx_data_i;
                    par_d     = frame_parity(tx_data_i, data_bits_i, parity_i == PAR_ODD);
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    sh_d = {1'b0, sh_q[7:1]};
                    if (bit_cnt_q == last_data_idx(cfg_q.data_bits)) begin
                        state_d   = has_parity(cfg_q.parity) ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == {3'b000, cfg_q.stop2}) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are one register behind the state, which gives the one-cycle
    // line latency after the transfer edge and keeps the pin glitch-free.
    always_comb begin
        line_d = 1'b1;
        busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        unique case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = sh_q[0];
            ST_PARITY: line_d = par_q;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rs232_tx_o = line_q;
    assign tx_busy_o  = busy_q;
    assign tx_done_o  = done_q;

endmodule
